// File: rtl/dock_cfg_pkg.sv
// Shared constants for the Dock config SPI bridge:
// SPI commands, status nibble, frame FSM states and decoder register offsets.
package dock_cfg_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_LOCK   = 8'h5A;
  localparam logic [3:0] STATUS_NIB = 4'hA;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    IGNORE
  } state_t;

  localparam logic [7:0] REG_BASE = 8'h00;
  localparam logic [7:0] REG_MASK = 8'h40;
  localparam logic [7:0] REG_SLOT = 8'h80;
  localparam logic [7:0] REG_OP   = 8'hC0;

endpackage

// File: rtl/spi_in_sync.sv
// SPI input synchronizer: SYNC_STAGES flops per input, registered edge pulses.
// Ports: clk, rst in; spi_sck/spi_cs_n/spi_mosi raw in;
//        sck_rise, sck_fall, cs_rise, cs_fall pulses and mosi_bit out.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sck,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_rise,
  output logic cs_fall,
  output logic mosi_bit
);

  logic [SYNC_STAGES-1:0] sck_ff;
  logic [SYNC_STAGES-1:0] cs_ff;
  logic [SYNC_STAGES-1:0] mosi_ff;
  logic sck_s, cs_s, sck_p, cs_p;

  assign sck_s = sck_ff[SYNC_STAGES-1];
  assign cs_s  = cs_ff[SYNC_STAGES-1];

  // Chains are not reset so a mid-frame rst does not fake a cs_n edge.
  always_ff @(posedge clk) begin
    sck_ff  <= {sck_ff[SYNC_STAGES-2:0], spi_sck};
    cs_ff   <= {cs_ff[SYNC_STAGES-2:0], spi_cs_n};
    mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], spi_mosi};
    sck_p   <= sck_s;
    cs_p    <= cs_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      cs_rise  <= 1'b0;
      cs_fall  <= 1'b0;
      mosi_bit <= 1'b0;
    end else begin
      sck_rise <= sck_s & ~sck_p;
      sck_fall <= ~sck_s & sck_p;
      cs_rise  <= cs_s & ~cs_p;
      cs_fall  <= ~cs_s & cs_p;
      mosi_bit <= mosi_ff[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/dock_cfg_spi_bridge.sv
// SPI-slave write port into the Dock decoder config bus (optional CFG_LOCK_EN).
// Ports: clk, rst; spi_sck/cs_n/mosi in, spi_miso out;
//        cfg_we/cfg_addr/cfg_wdata config bus, frame_err pulse, locked flag.
module dock_cfg_spi_bridge
  import dock_cfg_pkg::*;
#(
  parameter int CFG_AW      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              cfg_we,
  output logic [CFG_AW-1:0] cfg_addr,
  output logic [7:0]        cfg_wdata,
  output logic              frame_err,
  output logic              locked
);

  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_bit;

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall),
    .mosi_bit (mosi_bit)
  );

  state_t            state, state_d;
  logic [2:0]        cnt, cnt_nx;
  logic [6:0]        shreg;
  logic [7:0]        rx_byte;
  logic [7:0]        miso_sr;
  logic [CFG_AW-1:0] ptr;
  logic              bit_in, byte_done;
  logic              we_d, err_d, ptr_ld, ptr_inc;
`ifdef CFG_LOCK_EN
  logic              lock_set;
`endif

  // Bits only count inside a frame; after rst we wait for a fresh cs_n fall.
  assign bit_in    = sck_rise && (state != IDLE);
  assign cnt_nx    = bit_in ? cnt + 3'd1 : cnt;
  assign byte_done = bit_in && (cnt == 3'd7);
  assign rx_byte   = {shreg, mosi_bit};
  assign spi_miso  = miso_sr[7];

  always_comb begin
    state_d = state;
    we_d    = 1'b0;
    err_d   = 1'b0;
    ptr_ld  = 1'b0;
    ptr_inc = 1'b0;
`ifdef CFG_LOCK_EN
    lock_set = 1'b0;
`endif
    if (byte_done) begin
      unique case (state)
        CMD: begin
          state_d = IGNORE;
          if (rx_byte == CMD_WRITE) state_d = ADDR;
`ifdef CFG_LOCK_EN
          if (rx_byte == CMD_LOCK) lock_set = 1'b1;
`endif
        end
        ADDR: begin
          ptr_ld  = 1'b1;
          state_d = DATA;
        end
        DATA: begin
          ptr_inc = 1'b1;
          we_d    = ~locked;
        end
        default: ;
      endcase
    end
    // A byte finishing in the cs_n-rise cycle is processed above first.
    if (cs_rise) begin
      state_d = IDLE;
      err_d   = (cnt_nx != 3'd0);
    end else if (cs_fall && state == IDLE) begin
      state_d = CMD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 3'd0;
      shreg     <= 7'd0;
      ptr       <= '0;
      cfg_we    <= 1'b0;
      cfg_addr  <= '0;
      cfg_wdata <= 8'd0;
      frame_err <= 1'b0;
      miso_sr   <= 8'd0;
    end else begin
      cfg_we    <= we_d;
      frame_err <= err_d;
      if (cs_rise)     cnt <= 3'd0;
      else if (bit_in) cnt <= cnt_nx;
      if (bit_in) shreg <= rx_byte[6:0];
      if (ptr_ld)       ptr <= CFG_AW'(rx_byte);
      else if (ptr_inc) ptr <= ptr + 1'b1;
      if (we_d) begin
        cfg_addr  <= ptr;
        cfg_wdata <= rx_byte;
      end
      if (cs_fall && state == IDLE)
        miso_sr <= {STATUS_NIB, 3'b000, locked};
      else if (cs_rise)
        miso_sr <= 8'd0;
      else if (sck_fall && state != IDLE)
        miso_sr <= {miso_sr[6:0], 1'b0};
    end
  end

`ifdef CFG_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst)           locked <= 1'b0;
    else if (lock_set) locked <= 1'b1;
  end
`else
  assign locked = 1'b0;
`endif

endmodule

// File: doc/dock_cfg_spi_bridge.md
# dock_cfg_spi_bridge

SPI-slave configuration port for the Dock address decoder. Accepts write frames from the platform management MCU, synchronizes them into the core clock domain, and issues single-cycle byte writes on the decoder's config bus (cfg_we/cfg_addr/cfg_wdata). The window table (BASE, MASK, SLOT and OP registers) is loaded only through this port. The block sits directly upstream of the decoder's config inputs.

## Interface
- CFG_AW, 8, config address width; the address wraps modulo 2^CFG_AW.
- SYNC_STAGES, 2, flop stages on each SPI input (minimum 2).
- clk  in  1  core clock; wired to the decoder's cfg_clk.
- rst  in  1  synchronous, active-high reset.
- spi_sck  in  1  SPI clock, mode 0, asynchronous; maximum frequency clk/8.
- spi_cs_n  in  1  active-low frame select, asynchronous.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  status byte out, MSB first; driven 0 when not selected.
- cfg_we  out  1  one-clk write strobe to the decoder.
- cfg_addr  out  CFG_AW  write address; held stable between strobes.
- cfg_wdata  out  8  write data; held stable between strobes.
- frame_err  out  1  one-clk pulse when a frame ends mid-byte.
- locked  out  1  write lock active (constant 0 without CFG_LOCK_EN).

## Operation
- Each SPI input passes through SYNC_STAGES flops.
- A rising synchronized sck samples mosi into an 8-bit shift register. A 3-bit counter counts bits; the counter reaching 7 completes a byte.
- A falling synchronized sck shifts the next miso bit.
- Frame FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE: falling synced cs_n goes to CMD and loads the miso status byte.
  - CMD: byte 0x02 goes to ADDR. Byte 0x5A (lock command, with CFG_LOCK_EN) sets locked and goes to IGNORE. Any other byte goes to IGNORE.
  - ADDR: the byte loads the address pointer, then goes to DATA.
  - DATA: each completed byte drives cfg_wdata = byte, cfg_addr = pointer and pulses cfg_we. The pointer then increments, wrapping 0xFF to 0x00. The FSM stays in DATA.
  - IGNORE: bytes are discarded.
  - Any state: rising synced cs_n returns to IDLE and clears the bit counter.
- If the bit counter is nonzero at cs_n rise, frame_err pulses and the partial byte is dropped with no cfg_we.
- While locked, completed DATA bytes produce no cfg_we; the pointer still increments.
- Status byte on miso is {4'hA, 3'b000, locked}, shifted during the CMD byte. miso is 0 for all later bytes.

## Timing
- Reset values: cfg_we=0, cfg_addr=0, cfg_wdata=0, frame_err=0, locked=0, spi_miso=0, FSM=IDLE, bit counter=0.
- Write latency: cfg_we rises SYNC_STAGES+2 clk after the raw sck edge carrying the 8th data bit. It is high for exactly one clk.
- cfg_addr and cfg_wdata become valid in the same clk that cfg_we rises. They hold until the next strobe.
- Minimum spacing between strobes is 8 sck periods, which is at least 64 clk.
- A cs_n rise in the same clk as the 8th sck rise: the byte completes first (strobe issued), then the FSM returns to IDLE. No frame_err.
- rst asserted mid-frame: immediate return to reset values, including locked. Bits already received are lost. The SPI frame resumes only at the next cs_n fall.

## Configuration
- CFG_LOCK_EN defined: command 0x5A sets locked. locked clears only on rst. While locked, all config writes are suppressed.
- CFG_LOCK_EN undefined: 0x5A is treated like any unknown command (IGNORE). locked is tied to 0 and the status byte reads 0xA0.

## Structure
- Shared package dock_cfg_pkg holds:
  - command constants CMD_WRITE=8'h02 and CMD_LOCK=8'h5A;
  - the status nibble 4'hA;
  - the FSM state enum.
- The decoder's register-map offsets also live in dock_cfg_pkg, for use by the bench and firmware headers.
- Sub-module spi_in_sync: SYNC_STAGES flop chains plus rise/fall edge detect for sck and cs_n. It is instantiated once.

## Test plan
- Frame 02 00 00 00 00 10 → cfg_we pulses 4 times at addr 0x00..0x03 with data 00,00,00,10. miso reads 0xA0 during byte 0.
- Frame 02 FE 11 22 33 → writes 0xFE=11, 0xFF=22, 0x00=33 (address wrap).
- Frame 02 80 with cs_n raised after 5 bits of the data byte → no cfg_we, one frame_err pulse. The next frame writes normally.
- Frame 07 10 55 → no cfg_we, no frame_err.
- CFG_LOCK_EN: frame 5A, then 02 00 AA → locked=1, no cfg_we, status byte 0xA1. After rst, the same write strobes addr 0x00 with data 0xAA.
- rst pulsed after the address byte of 02 40 ..., then cs_n raised → all outputs return to reset values. A new frame 02 40 99 writes 0x40=99.
